oam_dma: RTL and testbench

Sprite-attribute DMA engine sitting directly downstream of `cpu` on the system bus. It snoops CPU writes; a write to the DMA trigger register halts the CPU via `ready` and takes the bus. It then copies 256 bytes from CPU page `{value, 8'h00}` to the PPU OAM data port, and returns the bus. When idle, it is a transparent pass-through between the CPU and the memory map.

---
 rtl/oam_dma.sv | 133 +++++++++++++
 tb/tb_oam_dma.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA engine on the CPU system bus.
// It snoops CPU writes. A write to DMA_REG_ADDR stalls the CPU and copies
// 256 bytes from page {value, 8'h00} to OAM_DATA_ADDR. It then returns the bus.
// While idle the block is a transparent CPU-to-memory-map pass-through.
//
// Optional feature: define OAM_DMA_ALIGN_EN to add the ALIGN state and the
// parity flop. The stall is then 513 or 514 cycles, depending on the clock
// parity seen in HALT.
//
// Ports:
//   clk, reset               system clock; asynchronous active-high reset
//   cpu_addr/write/d_out     CPU bus request (inputs)
//   cpu_ready                0 halts the CPU
//   bus_addr/write/d_out     request presented to the memory map
//   bus_d_in                 read data from the memory map
//   dma_active               high while the DMA owns the bus
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_d_out,
    output logic        cpu_ready,
    output logic [15:0] bus_addr,
    output logic        bus_write,
    output logic [7:0]  bus_d_out,
    input  logic [7:0]  bus_d_in,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3
`ifdef OAM_DMA_ALIGN_EN
        , S_ALIGN = 3'd4
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

`ifdef OAM_DMA_ALIGN_EN
    logic parity_q;

    // Free-running clock parity, used to line READs up on even cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= ~parity_q;
    end
`endif

    // Next-state and bus muxing
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        idx_d     = idx_q;
        data_d    = data_q;
        bus_addr  = {page_q, 8'h00};
        bus_write = 1'b0;
        bus_d_out = data_q;

        case (state_q)
            S_IDLE: begin
                // The trigger write itself also passes through to the bus
                bus_addr  = cpu_addr;
                bus_write = cpu_write;
                bus_d_out = cpu_d_out;
                if (cpu_write && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_d_out;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // Dummy read at {page, 00}; the data is discarded
`ifdef OAM_DMA_ALIGN_EN
                state_d = parity_q ? S_READ : S_ALIGN;
`else
                state_d = S_READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            S_ALIGN: begin
                state_d = S_READ;
            end
`endif
            S_READ: begin
                bus_addr = {page_q, idx_q};
                data_d   = bus_d_in;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_write = 1'b1;
                if (idx_q == 8'hFF) begin
                    state_d = S_IDLE;
                end else begin
                    // The index wraps in 8 bits, so reads never leave the page
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // CPU handshake is a decode of the registered state only
    assign cpu_ready  = (state_q == S_IDLE);
    assign dma_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma. A 64 KiB RAM model answers reads,
// and a monitor logs DMA reads and OAM writes for comparison against the
// hand-written source patterns.
module tb_oam_dma;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_d_out;
    logic        cpu_ready;
    logic [15:0] bus_addr;
    logic        bus_write;
    logic [7:0]  bus_d_out;
    logic [7:0]  bus_d_in;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    logic [15:0] cyc;
    logic [7:0]  oam_q[$];
    logic [15:0] rd_q[$];
    int          n_cmp;
    int          n_err;

    oam_dma dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_write  (cpu_write),
        .cpu_d_out  (cpu_d_out),
        .cpu_ready  (cpu_ready),
        .bus_addr   (bus_addr),
        .bus_write  (bus_write),
        .bus_d_out  (bus_d_out),
        .bus_d_in   (bus_d_in),
        .dma_active (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_d_in = mem[bus_addr];

    // Clock edges since reset release; bit 0 is the parity the DUT sees
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 16'd0;
        else       cyc <= cyc + 16'd1;
    end

    // Log DMA-owned bus traffic mid-cycle
    always @(negedge clk) begin
        if (!reset && dma_active) begin
            if (bus_write && bus_addr == 16'h2004) oam_q.push_back(bus_d_out);
            else if (!bus_write)                    rd_q.push_back(bus_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [7:0] pg, input logic [7:0] i);
        case (pg)
            8'h03:   pat = i ^ 8'h5A;
            8'h04:   pat = ~i;
            8'hFF:   pat = i ^ 8'hC3;
            default: pat = 8'hEE;
        endcase
    endfunction

    function automatic int exp_stall(input logic par);
`ifdef OAM_DMA_ALIGN_EN
        exp_stall = par ? 513 : 514;
`else
        exp_stall = 513;
`endif
    endfunction

    // Called at posedge+1; waits so the next edge leaves HALT parity p
    task automatic wait_par(input logic p);
        if (cyc[0] == p) begin
            @(posedge clk); #1;
        end
    endtask

    // Trigger a transfer and follow it; optional retrigger/reset at a byte
    task automatic run_dma(input logic [7:0] pg, input int rtrig, input int rst_at,
                           output int stall, output logic par);
        bit done;
        oam_q.delete();
        rd_q.delete();
        cpu_addr = 16'h4014; cpu_write = 1'b1; cpu_d_out = pg;
        @(posedge clk); #1;
        cpu_addr = 16'h0000; cpu_write = 1'b0; cpu_d_out = 8'h00;
        par = cyc[0];
        check("halt_ready",  32'(cpu_ready),  32'd0);
        check("halt_active", 32'(dma_active), 32'd1);
        check("halt_addr",   32'(bus_addr),   32'({pg, 8'h00}));
        check("halt_write",  32'(bus_write),  32'd0);
        stall = 1;
        done  = 1'b0;
        while (!done && !cpu_ready && stall < 700) begin
            if (rtrig >= 0 && !bus_write && bus_addr == {pg, 8'(rtrig)} && oam_q.size() == rtrig) begin
                cpu_addr = 16'h4014; cpu_write = 1'b1; cpu_d_out = 8'h07;
            end
            if (rst_at >= 0 && bus_write && oam_q.size() == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_ready",  32'(cpu_ready),  32'd1);
                check("rst_active", 32'(dma_active), 32'd0);
                check("rst_addr",   32'(bus_addr),   32'h0000);
                @(posedge clk); #1;
                reset = 1'b0;
                done  = 1'b1;
            end else begin
                @(posedge clk); #1;
                cpu_addr = 16'h0000; cpu_write = 1'b0; cpu_d_out = 8'h00;
                if (!cpu_ready) stall++;
            end
        end
    endtask

    task automatic check_copy(input logic [7:0] pg, input int stall, input logic par);
        int d;
        d = exp_stall(par) - 512;
        check("stall", 32'(stall), 32'(exp_stall(par)));
        check("n_wr",  32'(oam_q.size()), 32'd256);
        check("n_rd",  32'(rd_q.size()), 32'(256 + d));
        check("end_ready",  32'(cpu_ready),  32'd1);
        check("end_active", 32'(dma_active), 32'd0);
        for (int k = 0; k < d && k < rd_q.size(); k++)
            check("dummy_rd", 32'(rd_q[k]), 32'({pg, 8'h00}));
        for (int i = 0; i < 256; i++) begin
            if (i < oam_q.size())
                check($sformatf("wr%0d", i), 32'(oam_q[i]), 32'(pat(pg, 8'(i))));
            if (d + i < rd_q.size())
                check($sformatf("rd%0d", i), 32'(rd_q[d + i]), 32'({pg, 8'(i)}));
        end
    endtask

    initial begin
        int   st;
        logic pr;
        n_cmp = 0;
        n_err = 0;
        for (int a = 0; a < 65536; a++) mem[a] = pat(8'(a >> 8), 8'(a));

        // Reset state with pass-through
        reset = 1'b1; cpu_addr = 16'h1234; cpu_write = 1'b0; cpu_d_out = 8'h00;
        #12;
        check("rst0_ready",  32'(cpu_ready),  32'd1);
        check("rst0_active", 32'(dma_active), 32'd0);
        check("rst0_addr",   32'(bus_addr),   32'h1234);
        check("rst0_write",  32'(bus_write),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Idle pass-through of an unrelated write
        cpu_addr = 16'h4015; cpu_write = 1'b1; cpu_d_out = 8'hAA;
        #1;
        check("pt_addr",  32'(bus_addr),  32'h4015);
        check("pt_write", 32'(bus_write), 32'd1);
        check("pt_data",  32'(bus_d_out), 32'hAA);
        check("pt_ready", 32'(cpu_ready), 32'd1);
        @(posedge clk); #1;
        cpu_addr = 16'h0000; cpu_write = 1'b0; cpu_d_out = 8'h00;
        check("pt_ready2",  32'(cpu_ready),  32'd1);
        check("pt_active2", 32'(dma_active), 32'd0);

        // Basic copy, HALT parity 1 then parity 0
        wait_par(1'b1);
        run_dma(8'h03, -1, -1, st, pr);
        check_copy(8'h03, st, pr);
        @(posedge clk); #1;
        wait_par(1'b0);
        run_dma(8'h03, -1, -1, st, pr);
        check_copy(8'h03, st, pr);
        @(posedge clk); #1;

        // Retrigger to page 07 during byte 100 is ignored
        run_dma(8'h03, 100, -1, st, pr);
        check_copy(8'h03, st, pr);
        repeat (3) @(posedge clk);
        #1;
        check("retrig_idle", 32'(cpu_ready), 32'd1);

        // Reset during the WRITE of byte 17, then a fresh page-04 copy
        run_dma(8'h03, -1, 17, st, pr);
        check("abort_nwr",  32'(oam_q.size()), 32'd17);
        check("abort_last", 32'(oam_q.size() > 0 ? oam_q[oam_q.size() - 1] : 8'h00), 32'(pat(8'h03, 8'd16)));
        check("abort_ready", 32'(cpu_ready), 32'd1);
        @(posedge clk); #1;
        run_dma(8'h04, -1, -1, st, pr);
        check_copy(8'h04, st, pr);
        @(posedge clk); #1;

        // Page FF: index wraps inside the page, never touching $0000
        run_dma(8'hFF, -1, -1, st, pr);
        check_copy(8'hFF, st, pr);
        check("wrap_last", 32'(rd_q.size() > 0 ? rd_q[rd_q.size() - 1] : 16'h0000), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
